fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 28 ++
 rtl/mux4.sv | 31 +++
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the RISC-V core front end
//               (fetch FSM states, next-PC select codes, canonical NOP).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Fetch stage control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Next-PC select codes; the redirect_sel encoding reuses these directly
  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR = 2'b10;
  localparam logic [1:0] PC_SEL_TRAP = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/mux4.sv
`default_nettype none
// ============================================================================
// Module      : mux4
// Description : Generic 4:1 multiplexer, one select per data input in order
//               d0..d3.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  output logic [WIDTH-1:0] o_y
);

  // Pure combinational select; every select value maps to an input
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'b00:   o_y = i_d0;
      2'b01:   o_y = i_d1;
      2'b10:   o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule : mux4
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, keeps exactly one
//               request outstanding to instruction memory and hands each
//               fetched word to decode over valid/ready. Redirects from
//               execute/CSR override everything and may orphan an in-flight
//               response, which is then discarded via the drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  // instruction memory request
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  // instruction memory response
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  // redirect from execute / CSR
  input  logic            redirect_valid,
  input  logic [1:0]      redirect_sel,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] trap_vector,
  // decode handshake
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  // status
  output logic            pc_misaligned
);

  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req_valid;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [31:0]     r_if_instr;
  logic            r_pc_misaligned;
  logic            r_drop;

  logic            w_redirect;
  logic            w_handshake;
  logic [1:0]      w_pc_sel;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_target;
  logic [XLEN-1:0] w_next_pc;
  logic            w_target_misaligned;

  // A redirect with select 00 is a reserved encoding and must be a no-op
  assign w_redirect  = redirect_valid && (redirect_sel != PC_SEL_SEQ);
  // r_if_valid is only ever set while in HOLD, so this is the HOLD handshake
  assign w_handshake = r_if_valid && if_ready;
  assign w_pc_sel    = w_redirect ? redirect_sel : PC_SEL_SEQ;
  // Sequential increment wraps naturally at 2^XLEN
  assign w_pc_plus4  = r_pc + c_PC_STEP;

  mux4 #(
    .WIDTH (XLEN)
  ) u_next_pc_mux (
    .i_sel (w_pc_sel),
    .i_d0  (w_pc_plus4),
    .i_d1  (branch_target),
    .i_d2  (jalr_target),
    .i_d3  (trap_vector),
    .o_y   (w_pc_target)
  );

  // Fetch addresses are always word aligned; low bits are reported, not used
  assign w_next_pc           = {w_pc_target[XLEN-1:2], 2'b00};
  assign w_target_misaligned = w_redirect && (w_pc_target[1:0] != 2'b00);

  // Fetch FSM, PC register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_pc            <= RESET_PC;
      r_req_valid     <= 1'b0;
      r_if_valid      <= 1'b0;
      r_if_pc         <= RESET_PC;
      r_if_instr      <= INSTR_NOP;
      r_pc_misaligned <= 1'b0;
      r_drop          <= 1'b0;
    end else begin
      r_pc_misaligned <= w_target_misaligned;

      // PC moves on any effective redirect, or on a real decode handshake
      if (w_redirect || w_handshake) begin
        r_pc <= w_next_pc;
      end

      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_REQ;
          r_req_valid <= 1'b1;
        end

        ST_REQ: begin
          if (imem_req_ready) begin
            // A request accepted in the redirect cycle targets the old PC,
            // so its response has to be thrown away.
            r_state     <= ST_WAIT;
            r_req_valid <= 1'b0;
            r_drop      <= w_redirect;
          end else begin
            // Keep requesting; on redirect the address changes next cycle
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (imem_rsp_valid) begin
            r_drop <= 1'b0;
            if (w_redirect || r_drop) begin
              // Stale response: discard and fetch from the (new) PC
              r_state     <= ST_REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state    <= ST_HOLD;
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_instr <= imem_rsp_data;
            end
          end else if (w_redirect) begin
            // Response still in flight; remember it belongs to the old PC
            r_drop <= 1'b1;
          end
        end

        ST_HOLD: begin
          // A handshake coinciding with a redirect is void; either way
          // the next step is a fresh request from the updated PC.
          if (w_redirect || w_handshake) begin
            r_state     <= ST_REQ;
            r_req_valid <= 1'b1;
            r_if_valid  <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_valid <= 1'b0;
          r_if_valid  <= 1'b0;
          r_drop      <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;
  assign pc_misaligned  = r_pc_misaligned;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit: directed sequences for
//               start-up, backpressure, stale-response and reset corners, a
//               table of redirect vectors, and a randomized run against an
//               architectural model (expected PC stream + memory contents).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic [31:0] trap_vector;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        pc_misaligned;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .branch_target  (branch_target),
    .jalr_target    (jalr_target),
    .trap_vector    (trap_vector),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .pc_misaligned  (pc_misaligned)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        rdy;
    logic [31:0] br;
    logic [31:0] jr;
    logic [31:0] tr;
    logic        taken;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } redir_vec_t;

  redir_vec_t vecs [6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects REQ at addr; memory accepts at once and answers one cycle later.
  // Leaves the DUT in HOLD presenting the word.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, "_req_addr"}, imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check({tag, "_wait_noreq"}, 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    check({tag, "_if_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_if_pc"}, if_pc, addr);
    check({tag, "_if_instr"}, if_instr, data);
  endtask

  task automatic accept();
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] hold_pc;
    logic [31:0] pend_addr;
    logic [31:0] tgt;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic        pend;
    int          pend_cnt;
    logic        prev_redir;
    logic        prev_mis;
    logic        prev_valid;
    logic        prev_hs;
    logic        w_red;
    int          delivered;

    vecs[0] = '{sel: 2'b10, rdy: 1'b0, br: 32'h0BAD_0001, jr: 32'h0000_0202, tr: 32'h0BAD_0003,
                taken: 1'b1, exp_addr: 32'h0000_0200, exp_mis: 1'b1};
    vecs[1] = '{sel: 2'b00, rdy: 1'b0, br: 32'h0000_0500, jr: 32'h0000_0600, tr: 32'h0000_0700,
                taken: 1'b0, exp_addr: 32'h0000_0000, exp_mis: 1'b0};
    vecs[2] = '{sel: 2'b01, rdy: 1'b1, br: 32'h0000_0300, jr: 32'h0BAD_0002, tr: 32'h0BAD_0003,
                taken: 1'b1, exp_addr: 32'h0000_0300, exp_mis: 1'b0};
    vecs[3] = '{sel: 2'b11, rdy: 1'b0, br: 32'h0BAD_0001, jr: 32'h0BAD_0002, tr: 32'h0000_0041,
                taken: 1'b1, exp_addr: 32'h0000_0040, exp_mis: 1'b1};
    vecs[4] = '{sel: 2'b10, rdy: 1'b1, br: 32'h0BAD_0001, jr: 32'h0000_0400, tr: 32'h0BAD_0003,
                taken: 1'b1, exp_addr: 32'h0000_0400, exp_mis: 1'b0};
    vecs[5] = '{sel: 2'b01, rdy: 1'b0, br: 32'hFFFF_FFFE, jr: 32'h0BAD_0002, tr: 32'h0BAD_0003,
                taken: 1'b1, exp_addr: 32'hFFFF_FFFC, exp_mis: 1'b1};

    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_sel   = 2'b00;
    branch_target  = 32'h0;
    jalr_target    = 32'h0;
    trap_vector    = 32'h0;
    if_ready       = 1'b0;
    tick();
    tick();

    // ---- reset values ----
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0000_0013);
    check("rst_misaligned", 32'(pc_misaligned), 32'd0);

    // ---- start-up and zero-wait streaming ----
    rst = 1'b0;
    check("idle_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    do_fetch("seq0", 32'h0, 32'h1111_0001);
    accept();
    do_fetch("seq1", 32'h4, 32'h2222_0002);
    accept();
    do_fetch("seq2", 32'h8, 32'h3333_0003);

    // ---- decode backpressure ----
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_if_valid", 32'(if_valid), 32'd1);
      check("bp_if_pc", if_pc, 32'h8);
      check("bp_if_instr", if_instr, 32'h3333_0003);
      check("bp_no_req", 32'(imem_req_valid), 32'd0);
    end
    accept();

    // ---- branch redirect while waiting; stale response discarded ----
    check("pre_wait_addr", imem_req_addr, 32'hC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_sel   = 2'b01;
    branch_target  = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check("wredir_noreq", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("wredir_drop_valid", 32'(if_valid), 32'd0);
    do_fetch("br100", 32'h100, 32'h4444_0004);
    accept();

    // ---- trap redirect coinciding with request acceptance ----
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_sel   = 2'b11;
    trap_vector    = 32'h0000_0080;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    check("trap_noreq", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("trap_drop_valid", 32'(if_valid), 32'd0);
    do_fetch("trap80", 32'h80, 32'h5555_0005);
    accept();

    // ---- reset in WAIT, response in the following cycle ignored ----
    check("prerst_addr", imem_req_addr, 32'h84);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("rstw_if_valid", 32'(if_valid), 32'd0);
    check("rstw_if_instr", if_instr, 32'h0000_0013);
    do_fetch("rstw", 32'h0, 32'h6666_0006);
    hold_pc = 32'h0;

    // ---- redirect vector table, each applied from HOLD ----
    for (int v = 0; v < 6; v++) begin
      redirect_valid = 1'b1;
      redirect_sel   = vecs[v].sel;
      branch_target  = vecs[v].br;
      jalr_target    = vecs[v].jr;
      trap_vector    = vecs[v].tr;
      if_ready       = vecs[v].rdy;
      tick();
      redirect_valid = 1'b0;
      if_ready       = 1'b0;
      check($sformatf("vec%0d_mis", v), 32'(pc_misaligned), 32'(vecs[v].exp_mis));
      if (vecs[v].taken) begin
        check($sformatf("vec%0d_flush", v), 32'(if_valid), 32'd0);
        check($sformatf("vec%0d_req", v), 32'(imem_req_valid), 32'd1);
        check($sformatf("vec%0d_addr", v), imem_req_addr, vecs[v].exp_addr);
        tick();
        check($sformatf("vec%0d_mis_pulse", v), 32'(pc_misaligned), 32'd0);
        check($sformatf("vec%0d_addr_stable", v), imem_req_addr, vecs[v].exp_addr);
        do_fetch($sformatf("vec%0d", v), vecs[v].exp_addr, ~vecs[v].exp_addr);
        hold_pc = vecs[v].exp_addr;
      end else begin
        check($sformatf("vec%0d_hold", v), 32'(if_valid), 32'd1);
        check($sformatf("vec%0d_noreq", v), 32'(imem_req_valid), 32'd0);
        check($sformatf("vec%0d_pc", v), if_pc, hold_pc);
      end
    end

    // ---- sequential wrap from the top of the address space ----
    accept();
    check("wrap_req", 32'(imem_req_valid), 32'd1);
    check("wrap_addr", imem_req_addr, 32'h0);

    // ---- randomized run against an architectural model ----
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_pc     = 32'h0;
    pend       = 1'b0;
    pend_cnt   = 0;
    pend_addr  = 32'h0;
    prev_redir = 1'b0;
    prev_mis   = 1'b0;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_pc    = 32'h0;
    prev_instr = 32'h0;
    delivered  = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend           = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_sel   = 2'($urandom_range(0, 3));
      branch_target  = $urandom;
      jalr_target    = $urandom;
      trap_vector    = $urandom;

      @(negedge clk);
      w_red = redirect_valid && (redirect_sel != 2'b00);
      check("rnd_misaligned", 32'(pc_misaligned), 32'(prev_redir && prev_mis));
      if (prev_redir) begin
        check("rnd_flush", 32'(if_valid), 32'd0);
      end else if (prev_valid && !prev_hs) begin
        check("rnd_hold_valid", 32'(if_valid), 32'd1);
        check("rnd_hold_pc", if_pc, prev_pc);
        check("rnd_hold_instr", if_instr, prev_instr);
      end
      if (imem_req_valid) check("rnd_req_addr", imem_req_addr, exp_pc);
      if (if_valid && if_ready && !w_red) begin
        check("rnd_if_pc", if_pc, exp_pc);
        check("rnd_if_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (w_red) begin
        tgt = (redirect_sel == 2'b01) ? branch_target :
              (redirect_sel == 2'b10) ? jalr_target : trap_vector;
        exp_pc   = {tgt[31:2], 2'b00};
        prev_mis = (tgt[1:0] != 2'b00);
      end
      if (imem_req_valid && imem_req_ready) begin
        check("rnd_single_outstanding", 32'(pend), 32'd0);
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        pend_cnt  = $urandom_range(0, 2);
      end
      prev_redir = w_red;
      prev_valid = if_valid;
      prev_hs    = if_valid && if_ready;
      prev_pc    = if_pc;
      prev_instr = if_instr;
    end
    check("rnd_progress", 32'(delivered >= 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
